multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- cond  in  4  instruction condition field, Instr[31:28]
- op  in  2  instruction class, Instr[27:26]
- funct  in  6  Instr[25:20]: I bit, cmd[3:0], S bit
- rd  in  4  destination register, Instr[15:12]
- aluflags  in  4  ALU flags {N,Z,C,V}
- pcwrite  out  1  PC register enable
- memwrite  out  1  data memory write enable
- regwrite  out  1  register file write enable
- irwrite  out  1  instruction register enable
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALU result
- alusrca  out  1  ALU A select: 0 = register A, 1 = PC
- alusrcb  out  2  ALU B select: 00 = register B, 01 = extended immediate, 10 = constant 4
- resultsrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU result
- immsrc  out  2  equal to op
- regsrc  out  2  {op==01, op==10}
- alucontrol  out  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR
- state  out  4  current state encoding (debug)
- flags  out  4  registered {N,Z,C,V}

Function
REQ-002 The block SHALL implement a Moore FSM with the following states and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Encodings 10 to 15 SHALL be illegal.
REQ-003 The state transitions SHALL be:
- FETCH to DECODE.
- From DECODE: op=00 with funct[5]=0 goes to EXECR; op=00 with funct[5]=1 goes to EXECI; op=01 goes to MEMADR; op=10 goes to BRANCH; op=11 goes to FETCH.
- MEMADR goes to MEMRD if funct[0]=1, else to MEMWR.
- MEMRD to MEMWB. EXECR to ALUWB. EXECI to ALUWB.
- MEMWB, MEMWR, ALUWB and BRANCH go to FETCH.
- Any illegal state goes to FETCH on the next edge.
REQ-004 In FETCH the outputs SHALL be: irwrite=1, adrsrc=0, alusrca=1, alusrcb=10, resultsrc=10, pcwrite=1.
REQ-005 In DECODE the outputs SHALL be: alusrca=1, alusrcb=10, resultsrc=10. This computes PC+8.
REQ-006 In MEMADR the outputs SHALL be: alusrca=0, alusrcb=01, alucontrol=ADD.
REQ-007 In MEMRD and MEMWR, adrsrc SHALL be 1.
REQ-008 In MEMWR, memwrite SHALL be 1 only if condex=1.
REQ-009 In MEMWB the outputs SHALL be: resultsrc=01, regwrite=condex. If rd=15, pcwrite SHALL also equal condex.
REQ-010 In EXECR the ALU B select SHALL be alusrcb=00. In EXECI it SHALL be alusrcb=01. Both states SHALL use alusrca=0 and alucontrol decoded from cmd.
REQ-011 In ALUWB the outputs SHALL be: resultsrc=00, regwrite=condex AND (cmd not equal to 1010). If rd=15, pcwrite SHALL equal condex AND (cmd not equal to 1010).
REQ-012 In BRANCH the outputs SHALL be: alusrca=0, alusrcb=01, resultsrc=10, alucontrol=ADD, pcwrite=condex.
REQ-013 All enables and selects not listed for a state SHALL be 0. Enables SHALL be combinational from state and registered flags only, with no input-to-output path except through condex, immsrc and regsrc.
REQ-014 The cmd decode SHALL be:
- 0100 gives ADD.
- 0010 gives SUB.
- 1010 (CMP) gives SUB.
- 0000 gives AND.
- 1100 gives ORR.
- Any other cmd gives ADD with flag write suppressed.
REQ-015 condex SHALL be computed from cond and the registered flags:
- EQ: Z. NE: !Z. CS: C. CC: !C. MI: N. PL: !N. VS: V. VC: !V.
- HI: C&!Z. LS: !C|Z. GE: N==V. LT: N!=V.
- GT: !Z&(N==V). LE: Z|(N!=V). AL (1110): 1.
- 1111: 0.
REQ-016 The flag register SHALL update only on the clock edge that leaves EXECR or EXECI.
- N and Z SHALL load when S=1 and condex=1.
- C and V SHALL load when S=1, condex=1 and the cmd is ADD, SUB or CMP.
- For CMP, S SHALL be treated as 1 regardless of funct[0].
REQ-017 condex SHALL use the flags held before the current instruction's own update. Flags written in EXECx SHALL be visible to the next instruction's gating only.
REQ-018 The instruction latency SHALL be:
- Data-processing: 4 cycles.
- LDR: 5 cycles.
- STR: 4 cycles.
- Branch: 3 cycles.
- op=11: 2 cycles, with no architectural write.

Reset
REQ-019 When rst=0, the block SHALL asynchronously force state to FETCH and flags to 0000.
REQ-020 While rst=0, all outputs SHALL hold FETCH values except pcwrite, irwrite, regwrite and memwrite, which SHALL be 0.
REQ-021 After rst is deasserted, the first rising edge SHALL execute FETCH normally.
REQ-022 A reset asserted mid-instruction SHALL abort the instruction and SHALL NOT write the register file, memory or PC.

Verification
REQ-023 The bench SHALL cover: ADD R1 (cond=1110, op=00, funct=001000) -> state sequence 0,1,6,8,0 and regwrite=1 in ALUWB only.
REQ-024 The bench SHALL cover: SUBS with flags=0000 and aluflags=0110 -> flags=0110 after EXECR, then ADDEQ has regwrite=1 in ALUWB.
REQ-025 The bench SHALL cover: CMP (funct=010100) with aluflags=1000 -> flags=1000 and regwrite=0 in ALUWB.
REQ-026 The bench SHALL cover: LDR (op=01, funct[0]=1) with rd=15 -> states 0,1,2,3,4, and pcwrite=1 with resultsrc=01 in MEMWB.
REQ-027 The bench SHALL cover: BNE (cond=0001) with flags Z=1 -> pcwrite=0 in BRANCH; with Z=0 -> pcwrite=1.
REQ-028 The bench SHALL cover: rst=0 asserted during MEMWR -> memwrite drops to 0 immediately, state=0 and flags=0000.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle controller for a small ARM-style processor.
//
// A Moore FSM walks each instruction through FETCH/DECODE and then the
// memory, data-processing or branch path. Architectural write enables are
// gated by the condition check (condex), which is evaluated against the
// registered NZCV flags. Flags are only written on the edge leaving EXECR/EXECI.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   cond       Instr[31:28] condition field
//   op         Instr[27:26] instruction class
//   funct      Instr[25:20] {I, cmd[3:0], S}
//   rd         Instr[15:12] destination register
//   aluflags   ALU {N,Z,C,V}
//   pcwrite, memwrite, regwrite, irwrite   enables
//   adrsrc, alusrca, alusrcb, resultsrc    datapath selects
//   immsrc, regsrc                         decode helpers (from op)
//   alucontrol 00 ADD, 01 SUB, 10 AND, 11 ORR
//   state      current FSM state (debug)
//   flags      registered {N,Z,C,V}
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] aluflags,
    output logic       pcwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       irwrite,
    output logic       adrsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [1:0] immsrc,
    output logic [1:0] regsrc,
    output logic [1:0] alucontrol,
    output logic [3:0] state,
    output logic [3:0] flags
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    // condex captured when leaving EXECx: the instruction's own flag update
    // must not change the gating of its own write-back in ALUWB.
    logic       condex_hold_q, condex_hold_d;

    logic       condex;
    logic [3:0] cmd;
    logic       cmd_cmp, cmd_known, cmd_arith, s_eff, in_exec;
    logic [1:0] alu_dec;
    logic       pcwrite_raw, memwrite_raw, regwrite_raw, irwrite_raw;

    assign cmd     = funct[4:1];
    assign cmd_cmp = (cmd == 4'b1010);
    assign s_eff   = funct[0] | cmd_cmp;
    assign in_exec = (state_q == S_EXECR) || (state_q == S_EXECI);

    // Condition check against the registered flags.
    always_comb begin
        condex = 1'b0;
        case (cond)
            4'b0000: condex = flags_q[2];
            4'b0001: condex = ~flags_q[2];
            4'b0010: condex = flags_q[1];
            4'b0011: condex = ~flags_q[1];
            4'b0100: condex = flags_q[3];
            4'b0101: condex = ~flags_q[3];
            4'b0110: condex = flags_q[0];
            4'b0111: condex = ~flags_q[0];
            4'b1000: condex = flags_q[1] & ~flags_q[2];
            4'b1001: condex = ~flags_q[1] | flags_q[2];
            4'b1010: condex = (flags_q[3] == flags_q[0]);
            4'b1011: condex = (flags_q[3] != flags_q[0]);
            4'b1100: condex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: condex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    // ALU command decode; unknown commands fall back to ADD without flag writes.
    always_comb begin
        alu_dec   = 2'b00;
        cmd_known = 1'b1;
        cmd_arith = 1'b0;
        case (cmd)
            4'b0100: cmd_arith = 1'b1;
            4'b0010: begin alu_dec = 2'b01; cmd_arith = 1'b1; end
            4'b1010: begin alu_dec = 2'b01; cmd_arith = 1'b1; end
            4'b0000: alu_dec = 2'b10;
            4'b1100: alu_dec = 2'b11;
            default: cmd_known = 1'b0;
        endcase
    end

    always_comb begin
        flags_d       = flags_q;
        condex_hold_d = condex_hold_q;
        if (in_exec) begin
            condex_hold_d = condex;
            if (condex && s_eff && cmd_known) begin
                flags_d[3:2] = aluflags[3:2];
                if (cmd_arith) begin
                    flags_d[1:0] = aluflags[1:0];
                end
            end
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_FETCH;
            flags_q       <= 4'b0000;
            condex_hold_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flags_q       <= flags_d;
            condex_hold_q <= condex_hold_d;
        end
    end

    // Moore outputs; anything not set for a state stays 0.
    always_comb begin
        pcwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        adrsrc       = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        resultsrc    = 2'b00;
        alucontrol   = 2'b00;
        case (state_q)
            S_FETCH: begin
                irwrite_raw = 1'b1;
                pcwrite_raw = 1'b1;
                alusrca     = 1'b1;
                alusrcb     = 2'b10;
                resultsrc   = 2'b10;
            end
            S_DECODE: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
            end
            S_MEMADR: alusrcb = 2'b01;
            S_MEMRD:  adrsrc  = 1'b1;
            S_MEMWB: begin
                resultsrc    = 2'b01;
                regwrite_raw = condex;
                pcwrite_raw  = (rd == 4'd15) & condex;
            end
            S_MEMWR: begin
                adrsrc       = 1'b1;
                memwrite_raw = condex;
            end
            S_EXECR: alucontrol = alu_dec;
            S_EXECI: begin
                alusrcb    = 2'b01;
                alucontrol = alu_dec;
            end
            S_ALUWB: begin
                regwrite_raw = condex_hold_q & ~cmd_cmp;
                pcwrite_raw  = (rd == 4'd15) & condex_hold_q & ~cmd_cmp;
            end
            S_BRANCH: begin
                alusrcb     = 2'b01;
                resultsrc   = 2'b10;
                pcwrite_raw = condex;
            end
            default: ;
        endcase
    end

    // Reset blocks every architectural write immediately, even mid-cycle.
    assign pcwrite  = pcwrite_raw & rst;
    assign memwrite = memwrite_raw & rst;
    assign regwrite = regwrite_raw & rst;
    assign irwrite  = irwrite_raw & rst;

    assign immsrc = op;
    assign regsrc = {op == 2'b01, op == 2'b10};
    assign state  = state_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] aluflags;
    logic       pcwrite, memwrite, regwrite, irwrite, adrsrc, alusrca;
    logic [1:0] alusrcb, resultsrc, immsrc, regsrc, alucontrol;
    logic [3:0] state, flags;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] mflags;   // model flags {N,Z,C,V}

    multicycle_controller dut (
        .clk(clk), .rst(rst), .cond(cond), .op(op), .funct(funct), .rd(rd),
        .aluflags(aluflags), .pcwrite(pcwrite), .memwrite(memwrite),
        .regwrite(regwrite), .irwrite(irwrite), .adrsrc(adrsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc),
        .immsrc(immsrc), .regsrc(regsrc), .alucontrol(alucontrol),
        .state(state), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000:          return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    // Check every observable output for one cycle of an instruction.
    task automatic check_step(input int st, input bit cx, input logic [1:0] o,
                              input logic [5:0] f, input logic [3:0] r);
        logic [3:0] en;   // {pcwrite, memwrite, regwrite, irwrite}
        logic [7:0] sel;  // {adrsrc, alusrca, alusrcb, resultsrc, alucontrol}
        bit wb;
        wb  = cx && (f[4:1] != 4'b1010);
        en  = 4'b0000;
        sel = 8'h00;
        case (st)
            0: begin en = 4'b1001; sel = {1'b0, 1'b1, 2'b10, 2'b10, 2'b00}; end
            1: sel = {1'b0, 1'b1, 2'b10, 2'b10, 2'b00};
            2: sel = {1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
            3: sel = {1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
            4: begin en = {(r == 15) && cx, 1'b0, cx, 1'b0}; sel = {6'b000001, 2'b00}; end
            5: begin en = {1'b0, cx, 2'b00}; sel = {1'b1, 7'b0}; end
            6: sel = {6'b000000, alu_of(f[4:1])};
            7: sel = {6'b000100, alu_of(f[4:1])};
            8: en = {(r == 15) && wb, 1'b0, wb, 1'b0};
            9: begin en = {cx, 3'b000}; sel = {1'b0, 1'b0, 2'b01, 2'b10, 2'b00}; end
            default: ;
        endcase
        check("state", state, st);
        check("enables", {pcwrite, memwrite, regwrite, irwrite}, en);
        check("selects", {adrsrc, alusrca, alusrcb, resultsrc, alucontrol}, sel);
        check("immsrc_regsrc", {immsrc, regsrc}, {o, o == 2'b01, o == 2'b10});
        check("flags", flags, mflags);
    endtask

    // Run one whole instruction from FETCH; returns on the next FETCH.
    task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input logic [3:0] af);
        int  seq[$];
        bit  cx;
        logic [3:0] cmd;
        cond = c; op = o; funct = f; rd = r; aluflags = af;
        #1;
        cx  = cond_holds(c, mflags);
        cmd = f[4:1];
        seq = {0, 1};
        case (o)
            2'b00: begin seq.push_back(f[5] ? 7 : 6); seq.push_back(8); end
            2'b01: begin
                seq.push_back(2);
                if (f[0]) begin seq.push_back(3); seq.push_back(4); end
                else seq.push_back(5);
            end
            2'b10: seq.push_back(9);
            default: ;
        endcase
        foreach (seq[i]) begin
            check_step(seq[i], cx, o, f, r);
            if ((seq[i] == 6 || seq[i] == 7) && cx && (f[0] || cmd == 4'b1010)) begin
                if (cmd inside {4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100})
                    mflags[3:2] = af[3:2];
                if (cmd inside {4'b0100, 4'b0010, 4'b1010})
                    mflags[1:0] = af[1:0];
            end
            @(posedge clk);
            #1;
        end
        $display("[TB] instr cond=%h op=%0d funct=%b rd=%0d af=%b cx=%0d cycles=%0d flags=%b",
                 c, o, f, r, af, cx, seq.size(), mflags);
    endtask

    initial begin
        rst = 1'b0; cond = 4'hE; op = 2'b00; funct = 6'b0; rd = 4'd0; aluflags = 4'b0;
        mflags = 4'b0000;
        #2;
        check("reset_state", state, 0);
        check("reset_flags", flags, 0);
        check("reset_enables", {pcwrite, memwrite, regwrite, irwrite}, 0);
        check("reset_selects", {adrsrc, alusrca, alusrcb, resultsrc}, 6'b011010);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ADD R1
        run_instr(4'hE, 2'b00, 6'b001000, 4'd1, 4'b1111);
        // SUBS then ADDEQ
        run_instr(4'hE, 2'b00, 6'b000101, 4'd2, 4'b0110);
        check("subs_flags", flags, 4'b0110);
        run_instr(4'h0, 2'b00, 6'b001000, 4'd3, 4'b0000);
        // CMP
        run_instr(4'hE, 2'b00, 6'b010100, 4'd4, 4'b1000);
        check("cmp_flags", flags, 4'b1000);
        // LDR to PC
        run_instr(4'hE, 2'b01, 6'b000001, 4'd15, 4'b0000);
        // BNE with Z=0, then set Z=1 and BNE again
        run_instr(4'h1, 2'b10, 6'b100000, 4'd0, 4'b0000);
        run_instr(4'hE, 2'b00, 6'b010100, 4'd0, 4'b0100);
        run_instr(4'h1, 2'b10, 6'b100000, 4'd0, 4'b0000);
        // Data-processing writing PC, and op=11
        run_instr(4'hE, 2'b00, 6'b101000, 4'd15, 4'b0000);
        run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000);

        for (int i = 0; i < 250; i++) begin
            run_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                      6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)));
        end

        // Reset during MEMWR of an STR
        run_instr(4'hE, 2'b00, 6'b010100, 4'd0, 4'b1000);
        cond = 4'hE; op = 2'b01; funct = 6'b000000; rd = 4'd3; aluflags = 4'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("str_memwr_state", state, 5);
        check("str_memwrite", memwrite, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_memwrite", memwrite, 0);
        check("rst_state", state, 0);
        check("rst_flags", flags, 0);
        check("rst_enables", {pcwrite, memwrite, regwrite, irwrite}, 0);
        check("rst_selects", {adrsrc, alusrca, alusrcb, resultsrc}, 6'b011010);
        op = 2'b11;
        @(posedge clk); #1;
        check("rst_hold_state", state, 0);
        @(negedge clk);
        rst = 1'b1;
        mflags = 4'b0000;
        @(posedge clk); #1;
        check("post_rst_decode", state, 1);
        @(posedge clk); #1;
        check("post_rst_fetch", state, 0);
        run_instr(4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
